// File: rtl/fir_uart_pkg.sv
// fir_uart_pkg: shared types and constants for the FIR-to-UART transmit packer.
package fir_uart_pkg;
    localparam int SAMPLE_W = 16;
    localparam logic [SAMPLE_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [SAMPLE_W-1:0] SAT_NEG = 16'h8000;
    typedef enum logic [2:0] {IDLE, START0, ACK0, DONE0, START1, ACK1, DONE1} state_t;
endpackage

// File: rtl/fir_uart_tx_packer_sync_fifo.sv
// sync_fifo: single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int W = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && (!full || pop);
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fir_uart_tx_packer.sv
// fir_uart_tx_packer: slices/saturates FIR results to 16 bits, queues them and
// sends each sample as two bytes through the async_transmitter start/busy handshake.
module fir_uart_tx_packer
    import fir_uart_pkg::*;
#(
    parameter int IN_W = 38,
    parameter int SLICE_LSB = 8,
    parameter int SAT_EN = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int HI_FIRST = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          out_valid,
    input  logic [IN_W-1:0]               fir_out,
    input  logic                          tx_busy,
    output logic                          tx_start,
    output logic [7:0]                    tx_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          idle
);
    localparam int UW = IN_W - SLICE_LSB - 15;
    state_t state, next;
    logic [UW-1:0] upper;
    logic [SAMPLE_W-1:0] slice, sample, head, hold;
    logic [7:0] first, second;
    logic pop, full, empty, sat, unused_bits;

    // Upper bits must all equal the slice sign bit, otherwise the value does not fit.
    assign slice = fir_out[SLICE_LSB +: SAMPLE_W];
    assign upper = fir_out[IN_W-1 : SLICE_LSB+15];
    assign sat = (SAT_EN != 0) && (|upper) && !(&upper);
    assign sample = sat ? (fir_out[IN_W-1] ? SAT_NEG : SAT_POS) : slice;
    assign unused_bits = ^fir_out;

    assign pop = state == IDLE && !empty && !tx_busy;
    assign first = (HI_FIRST != 0) ? head[15:8] : head[7:0];
    assign second = (HI_FIRST != 0) ? hold[7:0] : hold[15:8];
    assign idle = state == IDLE && empty;

    sync_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) fifo (
        .clk(clk),
        .rst(rst),
        .push(out_valid),
        .pop(pop),
        .din(sample),
        .dout(head),
        .count(fifo_count),
        .full(full),
        .empty(empty)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = pop ? START0 : IDLE;
            START0:  next = ACK0;
            ACK0:    next = tx_busy ? DONE0 : ACK0;
            DONE0:   next = tx_busy ? DONE0 : START1;
            START1:  next = ACK1;
            ACK1:    next = tx_busy ? DONE1 : ACK1;
            DONE1:   next = tx_busy ? DONE1 : IDLE;
            default: next = IDLE;
        endcase
    end

    // tx_start/tx_data are registered off the transition so the pulse lines up with START0/START1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tx_start <= 1'b0;
            tx_data <= '0;
            hold <= '0;
            overflow <= 1'b0;
        end else begin
            state <= next;
            tx_start <= next == START0 || next == START1;
            if (pop) begin
                hold <= head;
                tx_data <= first;
            end else if (state == DONE0 && !tx_busy) begin
                tx_data <= second;
            end
            if (out_valid && full && !pop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fir_uart_tx_packer.sv
// tb_fir_uart_tx_packer: directed checks of three packer configurations (default, SAT_EN=0, HI_FIRST=1).
module tb_fir_uart_tx_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic out_valid = 1'b0;
    logic [37:0] fir_out = '0;
    logic [2:0] tx_start, idle, overflow;
    logic [2:0] tx_busy = '0;
    logic [7:0] tx_data [3];
    logic [2:0] fifo_count [3];
    logic [7:0] q0[$], q1[$], q2[$];
    int tests = 0, fails = 0, viol = 0;
    int lat = 1, len = 10;
    bit hold_busy = 1'b0;
    int w[3], r[3];
    bit armed[3];
    logic [7:0] held[3];

    fir_uart_tx_packer d0 (.clk(clk), .rst(rst), .out_valid(out_valid), .fir_out(fir_out),
        .tx_busy(tx_busy[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
        .fifo_count(fifo_count[0]), .overflow(overflow[0]), .idle(idle[0]));
    fir_uart_tx_packer #(.SAT_EN(0)) d1 (.clk(clk), .rst(rst), .out_valid(out_valid), .fir_out(fir_out),
        .tx_busy(tx_busy[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
        .fifo_count(fifo_count[1]), .overflow(overflow[1]), .idle(idle[1]));
    fir_uart_tx_packer #(.HI_FIRST(1)) d2 (.clk(clk), .rst(rst), .out_valid(out_valid), .fir_out(fir_out),
        .tx_busy(tx_busy[2]), .tx_start(tx_start[2]), .tx_data(tx_data[2]),
        .fifo_count(fifo_count[2]), .overflow(overflow[2]), .idle(idle[2]));

    always #5 clk = ~clk;

    // UART model per DUT: busy rises lat cycles after a start and stays high len cycles.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (tx_start[k] && tx_busy[k]) viol++;
            if (armed[k] && tx_busy[k] && tx_data[k] !== held[k]) viol++;
            if (tx_start[k]) begin
                w[k] = lat;
                armed[k] = 1'b1;
                held[k] = tx_data[k];
            end else if (w[k] > 0) begin
                w[k]--;
                if (w[k] == 0) r[k] = len;
            end else if (r[k] > 0) begin
                r[k]--;
            end
            if (rst) armed[k] = 1'b0;
            tx_busy[k] = hold_busy || r[k] > 0;
        end
        if (tx_start[0]) q0.push_back(tx_data[0]);
        if (tx_start[1]) q1.push_back(tx_data[1]);
        if (tx_start[2]) q2.push_back(tx_data[2]);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [15:0] s);
        out_valid = 1'b1;
        fir_out = {{14{s[15]}}, s, 8'h00};
        cyc();
    endtask

    task automatic clear_q();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(idle == 3'b111 && tx_busy == 3'b000) && n < 400) begin
            cyc();
            n++;
        end
        tests++;
        if (n >= 400) begin
            fails++;
            $display("FAIL %s idle timeout: idle=%b busy=%b", name, idle, tx_busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        @(negedge clk);
        tests += 5;
        if (tx_start[0] !== 1'b0) begin fails++; $display("FAIL reset tx_start got %b want 0", tx_start[0]); end
        if (tx_data[0] !== 8'h00) begin fails++; $display("FAIL reset tx_data got %h want 00", tx_data[0]); end
        if (fifo_count[0] !== 3'd0) begin fails++; $display("FAIL reset fifo_count got %0d want 0", fifo_count[0]); end
        if (overflow[0] !== 1'b0) begin fails++; $display("FAIL reset overflow got %b want 0", overflow[0]); end
        if (idle[0] !== 1'b1) begin fails++; $display("FAIL reset idle got %b want 1", idle[0]); end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        clear_q();
        out_valid = 1'b1;
        fir_out = 38'h00_0012_3456;
        cyc();
        out_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (fifo_count[0] !== 3'd1) begin fails++; $display("FAIL single count_c1 got %0d want 1", fifo_count[0]); end
        cyc();
        @(negedge clk);
        tests += 2;
        if (tx_start[0] !== 1'b1) begin fails++; $display("FAIL single start_c2 got %b want 1", tx_start[0]); end
        if (tx_data[0] !== 8'h34) begin fails++; $display("FAIL single data_c2 got %h want 34", tx_data[0]); end
        cyc();
        wait_idle("single");
        tests += 2;
        if (q0.size() != 2 || q0[0] !== 8'h34 || q0[1] !== 8'h12) begin
            fails++; $display("FAIL single bytes got %p want 34 12", q0);
        end
        if (idle[0] !== 1'b1) begin fails++; $display("FAIL single idle got %b want 1", idle[0]); end
    endtask

    task automatic test_saturation();
        logic [7:0] e0 [4];
        e0 = '{8'hFF, 8'h7F, 8'h00, 8'h80};
        clear_q();
        out_valid = 1'b1;
        fir_out = 38'h00_0100_0000;
        cyc();
        fir_out = 38'h3F_FE00_0000;
        cyc();
        out_valid = 1'b0;
        wait_idle("saturation");
        tests += 2;
        if (q0.size() != 4) begin fails++; $display("FAIL sat count got %0d want 4", q0.size()); end
        else for (int i = 0; i < 4; i++) begin
            tests++;
            if (q0[i] !== e0[i]) begin fails++; $display("FAIL sat byte%0d got %h want %h", i, q0[i], e0[i]); end
        end
        if (q1.size() != 4 || q1[0] !== 8'h00 || q1[1] !== 8'h00 || q1[2] !== 8'h00 || q1[3] !== 8'h00) begin
            fails++; $display("FAIL trunc bytes got %p want 00 00 00 00", q1);
        end
    endtask

    task automatic test_burst_overflow();
        logic [7:0] e [8];
        e = '{8'h01, 8'h11, 8'h02, 8'h11, 8'h03, 8'h11, 8'h04, 8'h11};
        clear_q();
        hold_busy = 1'b1;
        cyc();
        for (int i = 1; i <= 6; i++) push_sample(16'h1100 | 16'(i));
        out_valid = 1'b0;
        @(negedge clk);
        tests += 3;
        if (fifo_count[0] !== 3'd4) begin fails++; $display("FAIL burst count got %0d want 4", fifo_count[0]); end
        if (overflow[0] !== 1'b1) begin fails++; $display("FAIL burst overflow got %b want 1", overflow[0]); end
        if (q0.size() != 0) begin fails++; $display("FAIL burst early_start got %0d bytes want 0", q0.size()); end
        cyc();
        hold_busy = 1'b0;
        wait_idle("burst");
        tests++;
        if (q0.size() != 8) begin fails++; $display("FAIL burst bytes got %0d want 8", q0.size()); end
        else for (int i = 0; i < 8; i++) begin
            tests++;
            if (q0[i] !== e[i]) begin fails++; $display("FAIL burst byte%0d got %h want %h", i, q0[i], e[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        clear_q();
        push_sample(16'h2211);
        push_sample(16'h4433);
        push_sample(16'h6655);
        out_valid = 1'b0;
        while (!tx_busy[0] && n < 50) begin cyc(); n++; end
        tests++;
        if (n >= 50) begin fails++; $display("FAIL midrst busy timeout got %b want 1", tx_busy[0]); end
        repeat (2) cyc();
        @(negedge clk);
        tests++;
        if (fifo_count[0] !== 3'd2) begin fails++; $display("FAIL midrst queued got %0d want 2", fifo_count[0]); end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        tests += 3;
        if (fifo_count[0] !== 3'd0) begin fails++; $display("FAIL midrst count got %0d want 0", fifo_count[0]); end
        if (tx_start[0] !== 1'b0) begin fails++; $display("FAIL midrst tx_start got %b want 0", tx_start[0]); end
        if (overflow[0] !== 1'b0) begin fails++; $display("FAIL midrst overflow got %b want 0", overflow[0]); end
        cyc();
        wait_idle("midrst");
        repeat (5) cyc();
        tests++;
        if (q0.size() != 1 || q0[0] !== 8'h11) begin fails++; $display("FAIL midrst bytes got %p want 11", q0); end
    endtask

    task automatic test_handshake();
        clear_q();
        lat = 3;
        out_valid = 1'b1;
        fir_out = 38'h3F_FFAB_CD00;
        cyc();
        out_valid = 1'b0;
        wait_idle("handshake");
        tests += 3;
        if (q2.size() != 2 || q2[0] !== 8'hAB || q2[1] !== 8'hCD) begin
            fails++; $display("FAIL hifirst bytes got %p want AB CD", q2);
        end
        if (q0.size() != 2 || q0[0] !== 8'hCD || q0[1] !== 8'hAB) begin
            fails++; $display("FAIL lofirst bytes got %p want CD AB", q0);
        end
        if (viol != 0) begin fails++; $display("FAIL protocol violations got %0d want 0", viol); end
        lat = 1;
    endtask

    task automatic test_full_push_pop();
        clear_q();
        hold_busy = 1'b1;
        cyc();
        for (int i = 1; i <= 4; i++) push_sample(16'h5500 | 16'(i));
        out_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (fifo_count[0] !== 3'd4) begin fails++; $display("FAIL fullpp pre_count got %0d want 4", fifo_count[0]); end
        cyc();
        hold_busy = 1'b0;
        push_sample(16'h5505);
        out_valid = 1'b0;
        @(negedge clk);
        tests += 2;
        if (fifo_count[0] !== 3'd4) begin fails++; $display("FAIL fullpp count got %0d want 4", fifo_count[0]); end
        if (overflow[0] !== 1'b0) begin fails++; $display("FAIL fullpp overflow got %b want 0", overflow[0]); end
        cyc();
        wait_idle("fullpp");
        tests++;
        if (q0.size() != 10) begin fails++; $display("FAIL fullpp bytes got %0d want 10", q0.size()); end
        else for (int i = 0; i < 5; i++) begin
            tests++;
            if (q0[2*i] !== 8'(i + 1) || q0[2*i+1] !== 8'h55) begin
                fails++; $display("FAIL fullpp sample%0d got %h %h want %h 55", i, q0[2*i], q0[2*i+1], 8'(i + 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_burst_overflow();
        test_reset_mid_frame();
        test_handshake();
        test_full_push_pop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
